bkram_sd_xfer: RTL and testbench

BKRAM_SD_XFER -- requirements
Module: bkram_sd_xfer

---
 rtl/bkram_sd_xfer.sv | 173 +++++++++++++++++
 tb/tb_bkram_sd_xfer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkram_sd_xfer.sv
// Backup-RAM <-> SD image sector mover.
// Loads or saves the whole backup RAM one 512-byte sector at a time through
// the host sector-buffer handshake (sd_rd/sd_wr, sd_ack, buffer stream).
module bkram_sd_xfer #(
    parameter int SECTORS = 64,
    parameter int AW      = 14
) (
    input  logic          clk_sys,
    input  logic          reset_n,

    input  logic          img_mounted,
    input  logic          img_readonly,
    input  logic [63:0]   img_size,

    input  logic          bk_load,
    input  logic          bk_save,
    output logic          bk_ena,
    output logic          bk_loading,
    output logic          bk_saving,

    output logic [31:0]   sd_lba,
    output logic          sd_rd,
    output logic          sd_wr,
    input  logic          sd_ack,
    input  logic [7:0]    sd_buff_addr,
    input  logic [15:0]   sd_buff_dout,
    input  logic          sd_buff_wr,
    output logic [15:0]   sd_buff_din,

    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_wdata,
    output logic          ram_we,
    input  logic [15:0]   ram_rdata
);

    // Sector counter is one bit wider than the sector index so it can
    // reach SECTORS itself without wrapping.
    localparam int SW = AW - 8 + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_NEXT
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [SW-1:0]   r_sec;
    logic [SW-1:0]   w_sec_nx;
    logic            r_save;
    logic            w_save_nx;
    logic [SW-1:0]   r_nsec;
    logic            r_ena;
    logic            r_ro;
    logic            r_abort;
    logic            r_load_d;
    logic            r_save_d;
    logic            r_sd_rd;
    logic            r_sd_wr;
    logic [31:0]     r_lba;
    logic            r_loading;
    logic            r_saving;

    logic            w_load_edge;
    logic            w_save_edge;
    logic [54:0]     w_size_sec;
    logic [SW-1:0]   w_nsec;

    assign w_load_edge = bk_load & ~r_load_d;
    assign w_save_edge = bk_save & ~r_save_d;

    // Image size in whole sectors, clamped to the backup RAM capacity.
    assign w_size_sec = img_size[63:9];
    assign w_nsec     = (w_size_sec > 55'(SECTORS)) ? SW'(SECTORS) : SW'(w_size_sec);

    // Latch image properties on mount and register request levels for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ena    <= 1'b0;
            r_ro     <= 1'b0;
            r_nsec   <= '0;
            r_load_d <= 1'b0;
            r_save_d <= 1'b0;
        end else begin
            r_load_d <= bk_load;
            r_save_d <= bk_save;
            if (img_mounted) begin
                r_ena  <= (img_size != 64'd0) && (w_nsec != '0);
                r_ro   <= img_readonly;
                r_nsec <= w_nsec;
            end
        end
    end

    // State register plus registered host requests and busy flags derived from the next state.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_sec     <= '0;
            r_save    <= 1'b0;
            r_sd_rd   <= 1'b0;
            r_sd_wr   <= 1'b0;
            r_lba     <= '0;
            r_loading <= 1'b0;
            r_saving  <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sec     <= w_sec_nx;
            r_save    <= w_save_nx;
            r_sd_rd   <= (w_state_nx == S_REQ) && !w_save_nx;
            r_sd_wr   <= (w_state_nx == S_REQ) &&  w_save_nx;
            r_lba     <= 32'(w_sec_nx);
            r_loading <= (w_state_nx != S_IDLE) && !w_save_nx;
            r_saving  <= (w_state_nx != S_IDLE) &&  w_save_nx;
            // A remount mid-transfer lets the current sector finish, then stops.
            if (w_state_nx == S_IDLE)
                r_abort <= 1'b0;
            else if (img_mounted && (r_state != S_IDLE))
                r_abort <= 1'b1;
        end
    end

    // Next-state logic: start on request edges in IDLE, walk sectors until nsec or abort.
    always_comb begin
        w_state_nx = r_state;
        w_sec_nx   = r_sec;
        w_save_nx  = r_save;
        case (r_state)
            S_IDLE: begin
                if (w_load_edge && r_ena) begin
                    w_save_nx  = 1'b0;
                    w_sec_nx   = '0;
                    w_state_nx = S_REQ;
                end else if (w_save_edge && r_ena && !r_ro) begin
                    w_save_nx  = 1'b1;
                    w_sec_nx   = '0;
                    w_state_nx = S_REQ;
                end
            end
            S_REQ: begin
                if (sd_ack)
                    w_state_nx = S_XFER;
            end
            S_XFER: begin
                if (!sd_ack)
                    w_state_nx = S_NEXT;
            end
            S_NEXT: begin
                w_sec_nx = r_sec + 1'b1;
                if ((w_sec_nx == r_nsec) || r_abort)
                    w_state_nx = S_IDLE;
                else
                    w_state_nx = S_REQ;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign bk_ena      = r_ena;
    assign bk_loading  = r_loading;
    assign bk_saving   = r_saving;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign sd_lba      = r_lba;

    assign ram_addr    = {r_sec[AW-9:0], sd_buff_addr};
    assign ram_wdata   = sd_buff_dout;
    assign ram_we      = (r_state == S_XFER) && !r_save && sd_ack && sd_buff_wr;
    assign sd_buff_din = ram_rdata;

endmodule

// File: tb/tb_bkram_sd_xfer.sv
// Directed bench for bkram_sd_xfer: behavioural host and backup RAM,
// expected sector numbers queued at each start request.
module tb_bkram_sd_xfer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        img_mounted, img_readonly;
    logic [63:0] img_size;
    logic        bk_load, bk_save;
    logic        bk_ena, bk_loading, bk_saving;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout, sd_buff_din;
    logic        sd_buff_wr;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        ram_we;

    int total = 0;
    int bad   = 0;
    int q_lba[$];

    always #5 clk_sys = ~clk_sys;

    bkram_sd_xfer #(.SECTORS(64), .AW(14)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .bk_load(bk_load), .bk_save(bk_save),
        .bk_ena(bk_ena), .bk_loading(bk_loading), .bk_saving(bk_saving),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    // Backup RAM model with one-cycle read latency and a preload-with-~addr strobe.
    logic [15:0] mem [0:16383];
    logic        preload = 1'b0;
    always @(posedge clk_sys) begin
        if (preload) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 16'(~i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Free-running event counters; the stimulus compares deltas.
    int rd_rise = 0, wr_rise = 0, we_cnt = 0, we_over = 0, both_cnt = 0, saving_cyc = 0;
    int we_limit = 16384;
    logic p_rd = 1'b0, p_wr = 1'b0;
    always @(posedge clk_sys) begin
        if (sd_rd && !p_rd) rd_rise++;
        if (sd_wr && !p_wr) wr_rise++;
        p_rd = sd_rd;
        p_wr = sd_wr;
        if (ram_we) begin
            we_cnt++;
            if (int'(ram_addr) >= we_limit) we_over++;
        end
        if (bk_loading && bk_saving) both_cnt++;
        if (bk_saving) saving_cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mount(input logic [63:0] size, input logic ro);
        img_size     = size;
        img_readonly = ro;
        img_mounted  = 1'b1;
        @(negedge clk_sys);
        img_mounted  = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic pulse(input logic ld, input logic sv);
        bk_load = ld;
        bk_save = sv;
        @(negedge clk_sys);
        bk_load = 1'b0;
        bk_save = 1'b0;
    endtask

    task automatic wait_req(input logic save, output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if ((save ? sd_wr : sd_rd) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (!bk_loading && !bk_saving) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
    endtask

    // One full sector handshake as the host; expected lba taken from the queue.
    task automatic host_sector(input logic save);
        logic ok;
        int   lba;
        int   errs;
        lba = q_lba.pop_front();
        wait_req(save, ok);
        chk("req_seen", 64'(ok), 64'd1);
        if (!ok) return;
        chk("sd_lba", 64'(sd_lba), 64'(lba));
        chk("other_req_low", 64'(save ? sd_rd : sd_wr), 64'd0);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        chk("req_drop", 64'(save ? sd_wr : sd_rd), 64'd0);
        @(negedge clk_sys);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            sd_buff_addr = 8'(i);
            if (!save) begin
                sd_buff_dout = 16'(lba * 256 + i);
                sd_buff_wr   = 1'b1;
                @(negedge clk_sys);
            end else begin
                @(negedge clk_sys);
                if (sd_buff_din !== 16'(~(lba * 256 + i))) errs++;
                @(negedge clk_sys);
            end
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        if (save) chk("save_din_errs", 64'(errs), 64'd0);
    endtask

    initial begin
        logic ok;
        int   s_rd, s_wr, s_we, s_ov, s_sv, errs;

        reset_n = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0; img_size = '0;
        bk_load = 1'b0; bk_save = 1'b0; sd_ack = 1'b0; sd_buff_addr = '0;
        sd_buff_dout = '0; sd_buff_wr = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Reset state
        chk("rst_sd_rd", 64'(sd_rd), 64'd0);
        chk("rst_sd_wr", 64'(sd_wr), 64'd0);
        chk("rst_bk_ena", 64'(bk_ena), 64'd0);
        chk("rst_busy", 64'({bk_loading, bk_saving}), 64'd0);
        chk("rst_lba", 64'(sd_lba), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Full 64-sector load, host word = lba*256+n
        mount(64'd32768, 1'b0);
        chk("ena_32k", 64'(bk_ena), 64'd1);
        s_rd = rd_rise; s_we = we_cnt;
        pulse(1'b1, 1'b0);
        chk("load_busy", 64'({bk_loading, bk_saving}), 64'b10);
        for (int k = 0; k < 64; k++) q_lba.push_back(k);
        for (int k = 0; k < 64; k++) host_sector(1'b0);
        chk("load_busy_after_last", 64'(bk_loading), 64'd1);
        wait_idle(ok);
        chk("load_done", 64'(ok), 64'd1);
        repeat (10) @(negedge clk_sys);
        chk("load_req_count", 64'(rd_rise - s_rd), 64'd64);
        chk("load_we_count", 64'(we_cnt - s_we), 64'd16384);
        chk("ram_0100", 64'(mem[14'h0100]), 64'h0100);
        errs = 0;
        for (int a = 0; a < 16384; a++) if (mem[a] !== 16'(a)) errs++;
        chk("load_image_errs", 64'(errs), 64'd0);

        // Two-sector image: nothing beyond word 0x1FF
        mount(64'd1024, 1'b0);
        we_limit = 'h200;
        s_rd = rd_rise; s_we = we_cnt; s_ov = we_over;
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) q_lba.push_back(k);
        for (int k = 0; k < 2; k++) host_sector(1'b0);
        wait_idle(ok);
        chk("small_done", 64'(ok), 64'd1);
        repeat (20) @(negedge clk_sys);
        chk("small_req_count", 64'(rd_rise - s_rd), 64'd2);
        chk("small_we_count", 64'(we_cnt - s_we), 64'd512);
        chk("small_we_over", 64'(we_over - s_ov), 64'd0);
        we_limit = 16384;

        // Full save of ~addr preload
        preload = 1'b1;
        @(negedge clk_sys);
        preload = 1'b0;
        mount(64'd32768, 1'b0);
        s_rd = rd_rise; s_wr = wr_rise; s_we = we_cnt;
        pulse(1'b0, 1'b1);
        chk("save_busy", 64'({bk_loading, bk_saving}), 64'b01);
        for (int k = 0; k < 64; k++) q_lba.push_back(k);
        for (int k = 0; k < 64; k++) host_sector(1'b1);
        wait_idle(ok);
        chk("save_done", 64'(ok), 64'd1);
        chk("save_wr_count", 64'(wr_rise - s_wr), 64'd64);
        chk("save_no_rd", 64'(rd_rise - s_rd), 64'd0);
        chk("save_no_we", 64'(we_cnt - s_we), 64'd0);

        // Read-only image refuses save
        mount(64'd32768, 1'b1);
        s_wr = wr_rise; s_sv = saving_cyc;
        pulse(1'b0, 1'b1);
        repeat (20) @(negedge clk_sys);
        chk("ro_no_wr", 64'(wr_rise - s_wr), 64'd0);
        chk("ro_no_saving", 64'(saving_cyc - s_sv), 64'd0);

        // Simultaneous load and save edges: load wins
        mount(64'd2048, 1'b0);
        s_wr = wr_rise; s_rd = rd_rise;
        pulse(1'b1, 1'b1);
        chk("both_busy", 64'({bk_loading, bk_saving}), 64'b10);
        for (int k = 0; k < 4; k++) q_lba.push_back(k);
        for (int k = 0; k < 4; k++) host_sector(1'b0);
        wait_idle(ok);
        chk("both_done", 64'(ok), 64'd1);
        chk("both_no_wr", 64'(wr_rise - s_wr), 64'd0);
        chk("both_rd_count", 64'(rd_rise - s_rd), 64'd4);
        chk("never_both_busy", 64'(both_cnt), 64'd0);

        // Remount mid-transfer: finish current sector, then stop
        mount(64'd32768, 1'b0);
        s_rd = rd_rise;
        pulse(1'b1, 1'b0);
        wait_req(1'b0, ok);
        chk("abort_req_seen", 64'(ok), 64'd1);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b1;
        @(negedge clk_sys);
        img_mounted = 1'b0;
        repeat (4) @(negedge clk_sys);
        sd_ack = 1'b0;
        wait_idle(ok);
        chk("abort_idle", 64'(ok), 64'd1);
        repeat (20) @(negedge clk_sys);
        chk("abort_req_count", 64'(rd_rise - s_rd), 64'd1);

        // Stray ack while idle writes nothing
        s_we = we_cnt;
        sd_ack = 1'b1; sd_buff_wr = 1'b1; sd_buff_addr = 8'h33; sd_buff_dout = 16'hBEEF;
        repeat (4) @(negedge clk_sys);
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        chk("stray_ack_no_we", 64'(we_cnt - s_we), 64'd0);

        // Reset during lba 5 acknowledge
        pulse(1'b1, 1'b0);
        for (int k = 0; k < 64; k++) q_lba.push_back(k);
        for (int k = 0; k < 5; k++) host_sector(1'b0);
        wait_req(1'b0, ok);
        chk("rst_lba5_seen", 64'(ok), 64'd1);
        chk("rst_lba5", 64'(sd_lba), 64'd5);
        sd_ack = 1'b1; sd_buff_wr = 1'b1;
        s_we = we_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_sd_rd", 64'(sd_rd), 64'd0);
        chk("mid_rst_loading", 64'(bk_loading), 64'd0);
        chk("mid_rst_ram_we", 64'(ram_we), 64'd0);
        q_lba.delete();
        repeat (3) @(negedge clk_sys);
        chk("mid_rst_no_we", 64'(we_cnt - s_we), 64'd0);
        sd_ack = 1'b0; sd_buff_wr = 1'b0;
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("post_rst_ena", 64'(bk_ena), 64'd0);
        s_rd = rd_rise;
        pulse(1'b1, 1'b0);
        repeat (20) @(negedge clk_sys);
        chk("post_rst_no_load", 64'(rd_rise - s_rd), 64'd0);
        mount(64'd1024, 1'b0);
        chk("remount_ena", 64'(bk_ena), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
